// File: rtl/shop_cmd_arbiter.sv
// Round-robin arbiter that multiplexes NUM_REQ requesters onto one shop_v
// command port. It runs the shop handshake for each grant: data held, a
// one-cycle rdy strobe, then a fixed wait. The shop's response is returned
// to the granted requester together with a one-cycle ack.
module shop_cmd_arbiter #(
  parameter int NUM_REQ             = 4,
  parameter int I_A_NUM_ASCII_CHARS = 7,
  parameter int O_A_NUM_ASCII_CHARS = 9,
  parameter int I_U_NUM_BITS        = 4,
  parameter int MAX_USERS           = 5,
  parameter int RESP_WAIT           = 2,
  localparam int I_A_NUM_BITS       = 8 * I_A_NUM_ASCII_CHARS,
  localparam int O_A_NUM_BITS       = 8 * O_A_NUM_ASCII_CHARS
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic [NUM_REQ-1:0]                i_req,
  input  logic [NUM_REQ*I_U_NUM_BITS-1:0]   i_req_u,
  input  logic [NUM_REQ*I_A_NUM_BITS-1:0]   i_req_a,
  output logic [NUM_REQ-1:0]                o_ack,
  output logic [O_A_NUM_BITS-1:0]           o_resp,
  output logic [2:0]                        o_grant_id,
  output logic                              o_busy,
  output logic [I_U_NUM_BITS-1:0]           o_shop_u,
  output logic [I_A_NUM_BITS-1:0]           o_shop_a,
  output logic                              o_shop_rdy,
  input  logic [O_A_NUM_BITS-1:0]           i_shop_a
);

  localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (RESP_WAIT > 2) ? $clog2(RESP_WAIT) : 1;
  localparam logic [O_A_NUM_BITS-1:0] BAD_USER = O_A_NUM_BITS'("BadUser");

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4,
    REJECT = 3'd5
  } state_t;

  state_t                  state;
  logic [2:0]              last_grant;
  logic [CNT_W-1:0]        wait_cnt;
  logic                    rej_ack_done;

  logic [2:0]              pick;
  logic                    pick_valid;
  logic [I_U_NUM_BITS-1:0] pick_u;
  logic [I_A_NUM_BITS-1:0] pick_a;
  logic [NUM_REQ-1:0]      grant_onehot;

  // Round-robin search: nearest requester above last_grant wins (scan far to near).
  always_comb begin
    pick       = 3'd0;
    pick_valid = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (i_req[IDX_W'((int'(last_grant) + i) % NUM_REQ)]) begin
        pick       = 3'((int'(last_grant) + i) % NUM_REQ);
        pick_valid = 1'b1;
      end
    end
  end

  // Grantee payload slices and the ack pattern for the current grant.
  always_comb begin
    pick_u       = i_req_u[int'(pick)*I_U_NUM_BITS +: I_U_NUM_BITS];
    pick_a       = i_req_a[int'(pick)*I_A_NUM_BITS +: I_A_NUM_BITS];
    grant_onehot = NUM_REQ'(1) << o_grant_id;
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      last_grant   <= 3'(NUM_REQ - 1);
      wait_cnt     <= '0;
      rej_ack_done <= 1'b0;
      o_ack        <= '0;
      o_resp       <= '0;
      o_grant_id   <= 3'd0;
      o_busy       <= 1'b0;
      o_shop_u     <= '0;
      o_shop_a     <= '0;
      o_shop_rdy   <= 1'b0;
    end else begin
      o_shop_rdy <= 1'b0;
      o_ack      <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            o_shop_u   <= pick_u;
            o_shop_a   <= pick_a;
            o_grant_id <= pick;
            o_busy     <= 1'b1;
            state      <= (int'(pick_u) >= MAX_USERS) ? REJECT : SETUP;
          end
        end
        SETUP: begin
          // Data has been stable for a cycle; strobe next.
          o_shop_rdy <= 1'b1;
          state      <= STROBE;
        end
        STROBE: begin
          wait_cnt <= CNT_W'(RESP_WAIT - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            o_resp <= i_shop_a;
            o_ack  <= grant_onehot;
            state  <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          last_grant <= o_grant_id;
          o_busy     <= 1'b0;
          state      <= IDLE;
        end
        REJECT: begin
          // First cycle loads the reject response and ack; second cycle shows them.
          if (!rej_ack_done) begin
            o_resp       <= BAD_USER;
            o_ack        <= grant_onehot;
            rej_ack_done <= 1'b1;
          end else begin
            rej_ack_done <= 1'b0;
            last_grant   <= o_grant_id;
            o_busy       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shop_cmd_arbiter.sv
// Directed bench for shop_cmd_arbiter with a small shop_v response model.
module tb_shop_cmd_arbiter;

  localparam int NR  = 4;
  localparam int UB  = 4;
  localparam int IAB = 56;
  localparam int OAB = 72;
  localparam int RW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*UB-1:0]  req_u;
  logic [NR*IAB-1:0] req_a;
  logic [NR-1:0]     ack;
  logic [OAB-1:0]    resp;
  logic [2:0]        grant_id;
  logic              busy;
  logic [UB-1:0]     shop_u;
  logic [IAB-1:0]    shop_a;
  logic              shop_rdy;
  logic [OAB-1:0]    shop_resp;

  int checks = 0;
  int errors = 0;
  int rdy_cnt = 0;
  int rdy_dbl = 0;
  int ack_bad = 0;
  logic prev_rdy = 1'b0;

  shop_cmd_arbiter dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_req      (req),
    .i_req_u    (req_u),
    .i_req_a    (req_a),
    .o_ack      (ack),
    .o_resp     (resp),
    .o_grant_id (grant_id),
    .o_busy     (busy),
    .o_shop_u   (shop_u),
    .o_shop_a   (shop_a),
    .o_shop_rdy (shop_rdy),
    .i_shop_a   (shop_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OAB-1:0] model_resp(input logic [IAB-1:0] a, input logic [UB-1:0] u);
    if (a == IAB'("Login")) return OAB'("OK");
    return OAB'({8'h52, 8'h30 + 8'(u)});
  endfunction

  // Shop model: response valid only in the last cycle of the wait window.
  logic [3:0]     cd = 4'd0;
  logic [OAB-1:0] pend = '0;
  always @(posedge clk) begin
    shop_resp <= '0;
    if (shop_rdy) begin
      cd   <= 4'(RW);
      pend <= model_resp(shop_a, shop_u);
    end else if (cd != 4'd0) begin
      cd <= cd - 4'd1;
      if (cd == 4'd2) shop_resp <= pend;
    end
  end

  // Protocol monitor sampled away from the active edge.
  always @(negedge clk) begin
    if (shop_rdy) rdy_cnt++;
    if (shop_rdy && prev_rdy) rdy_dbl++;
    prev_rdy = shop_rdy;
    if (!$onehot0(ack)) ack_bad++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [UB-1:0] u, input logic [IAB-1:0] a);
    req_u[k*UB +: UB]    = u;
    req_a[k*IAB +: IAB]  = a;
    req[k]               = 1'b1;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  int exp_k[5] = '{0, 1, 2, 3, 0};
  int t;
  int waited;
  int rdy_snap;
  logic [3:0] oh;

  initial begin
    shop_resp = '0;
    rst_n = 1'b0;
    req   = '0;
    req_u = '0;
    req_a = '0;
    for (int k = 0; k < NR; k++) set_req(k, UB'(k), IAB'({"Cmd", 8'h30 + 8'(k)}));

    // Reset held 2 cycles with all requesting.
    cyc(); cyc();
    chk("rst_ack", ack, 0);
    chk("rst_resp", resp, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", shop_rdy, 0);
    chk("rst_shop_u", shop_u, 0);
    chk("rst_shop_a", shop_a, 0);

    // Round robin from release: acks at cycles 5,11,17,... in order 0,1,2,3,0.
    rst_n = 1'b1;
    t = 0;
    cyc(); t++;
    chk("rr_first_grant", grant_id, 0);
    chk("rr_first_busy", busy, 1);
    for (int n = 0; n < 5; n++) begin
      waited = 0;
      while (ack == '0 && waited < 20) begin
        cyc(); t++; waited++;
      end
      oh = 4'b0001 << exp_k[n];
      chk("rr_ack", ack, oh);
      chk("rr_time", t, 5 + 6*n);
      chk("rr_resp", resp, model_resp(IAB'({"Cmd", 8'h30 + 8'(exp_k[n])}), UB'(exp_k[n])));
      if (n == 4) req = '0;
      cyc(); t++;
    end
    chk("rr_idle_after", busy, 0);

    // Single accepted request from requester 2.
    set_req(2, 4'd4, IAB'("Login"));
    rdy_snap = rdy_cnt;
    cyc();
    chk("s_c1_busy", busy, 1);
    chk("s_c1_rdy", shop_rdy, 0);
    chk("s_c1_u", shop_u, 4);
    chk("s_c1_a", shop_a, IAB'("Login"));
    cyc();
    chk("s_c2_rdy", shop_rdy, 1);
    chk("s_c2_u", shop_u, 4);
    chk("s_c2_a", shop_a, IAB'("Login"));
    cyc();
    chk("s_c3_rdy", shop_rdy, 0);
    chk("s_c3_ack", ack, 0);
    cyc();
    chk("s_c4_ack", ack, 0);
    cyc();
    chk("s_c5_ack", ack, 4'b0100);
    chk("s_c5_resp", resp, OAB'("OK"));
    req = '0;
    cyc();
    chk("s_c6_ack", ack, 0);
    chk("s_c6_busy", busy, 0);
    chk("s_rdy_count", rdy_cnt - rdy_snap, 1);

    // Reject: user 7 is out of range.
    set_req(1, 4'd7, IAB'("Buy"));
    rdy_snap = rdy_cnt;
    cyc();
    chk("r_c1_busy", busy, 1);
    chk("r_c1_ack", ack, 0);
    chk("r_c1_grant", grant_id, 1);
    cyc();
    chk("r_c2_ack", ack, 4'b0010);
    chk("r_c2_resp", resp, OAB'("BadUser"));
    req = '0;
    cyc();
    chk("r_c3_ack", ack, 0);
    chk("r_c3_busy", busy, 0);
    chk("r_no_strobe", rdy_cnt - rdy_snap, 0);

    // Requester 3 drops its request right after the grant.
    set_req(3, 4'd2, IAB'("Logout"));
    cyc();
    chk("d_c1_grant", grant_id, 3);
    req = '0;
    cyc(); cyc(); cyc(); cyc();
    chk("d_c5_ack", ack, 4'b1000);
    chk("d_c5_resp", resp, OAB'({8'h52, 8'h32}));
    cyc();
    chk("d_c6_busy", busy, 0);
    cyc();
    chk("d_c7_busy", busy, 0);

    // Reset in the middle of WAIT; later requests from 1 and 3 are pending.
    set_req(0, 4'd1, IAB'("Login"));
    rdy_snap = rdy_cnt;
    cyc();
    set_req(1, 4'd3, IAB'("Cart"));
    set_req(3, 4'd0, IAB'("Help"));
    cyc(); cyc();
    chk("m_c3_strobed", rdy_cnt - rdy_snap, 1);
    rst_n  = 1'b0;
    req[0] = 1'b0;
    cyc();
    chk("m_rst_ack", ack, 0);
    chk("m_rst_busy", busy, 0);
    chk("m_rst_rdy", shop_rdy, 0);
    chk("m_rst_resp", resp, 0);
    chk("m_rst_grant", grant_id, 0);
    rst_n = 1'b1;
    cyc();
    chk("m_c1_grant", grant_id, 1);
    chk("m_c1_u", shop_u, 3);
    chk("m_no_ack_c1", ack, 0);
    chk("m_no_restrobe", rdy_cnt - rdy_snap, 1);
    cyc(); cyc(); cyc(); cyc();
    chk("m_c5_ack", ack, 4'b0010);
    chk("m_c5_resp", resp, OAB'({8'h52, 8'h33}));
    req = '0;
    cyc(); cyc();

    chk("rdy_never_double", rdy_dbl, 0);
    chk("ack_onehot", ack_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shop_cmd_arbiter.md
# shop_cmd_arbiter

Round-robin command arbiter that shares the single `shop_v` command port between `NUM_REQ` independent requesters (terminals). Each request is a user ID plus an ASCII command word. The arbiter sequences every granted request onto the shop with the same handshake the shop benches use: data stable, one-cycle `rdy` strobe, fixed response wait. It then returns the shop's ASCII response to the granted requester with a one-cycle acknowledge. It sits directly in front of `shop_v`, and its shop-side outputs connect to `shop_v.i_u`, `i_a`, `i_rdy` and `o_a`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `I_A_NUM_ASCII_CHARS`, 7: command width in characters; must fit the longest CMD_KEY.
- `O_A_NUM_ASCII_CHARS`, 9: response width in characters.
- `I_U_NUM_BITS`, 4: user ID width, 15 max.
- `MAX_USERS`, 5: number of user IDs the shop accepts, admin included.
- `RESP_WAIT`, 2: cycles from the `rdy` strobe to a valid shop response, minimum 1.
- Derived: `I_A_NUM_BITS = 8*I_A_NUM_ASCII_CHARS` and `O_A_NUM_BITS = 8*O_A_NUM_ASCII_CHARS`.

Ports (name, direction, width, meaning):
- `i_clk`, in, 1: the single clock; all logic on the rising edge.
- `i_reset_n`, in, 1: synchronous, active-low reset.
- `i_req`, in, NUM_REQ: per-requester request level.
- `i_req_u`, in, NUM_REQ*I_U_NUM_BITS: packed user IDs; requester k occupies slice k.
- `i_req_a`, in, NUM_REQ*I_A_NUM_BITS: packed ASCII commands; requester k occupies slice k.
- `o_ack`, out, NUM_REQ: one-hot, one-cycle completion pulse.
- `o_resp`, out, O_A_NUM_BITS: response for the acknowledged requester.
- `o_grant_id`, out, 3: index of the current or last granted requester.
- `o_busy`, out, 1: high whenever the FSM is not in IDLE.
- `o_shop_u`, out, I_U_NUM_BITS: to `shop_v.i_u`.
- `o_shop_a`, out, I_A_NUM_BITS: to `shop_v.i_a`.
- `o_shop_rdy`, out, 1: to `shop_v.i_rdy`.
- `i_shop_a`, in, O_A_NUM_BITS: from `shop_v.o_a`.

## Operation
- **FSM states:** IDLE, SETUP, STROBE, WAIT, RESP, REJECT.
- **IDLE.** If any `i_req` bit is set, grant the first requester searching upward from `last_grant+1`, modulo NUM_REQ.
  - Register the grantee's u/a into `o_shop_u`/`o_shop_a` and set `o_grant_id`.
  - If the granted u is at or above MAX_USERS, go to REJECT; otherwise go to SETUP.
  - If no request is set, stay in IDLE.
- **SETUP.** Hold the shop data with `o_shop_rdy=0` for 1 cycle, then go to STROBE.
- **STROBE.** `o_shop_rdy=1` for exactly 1 cycle. Load the wait counter with RESP_WAIT-1 and go to WAIT.
- **WAIT.** Decrement the counter each cycle. At 0, register `i_shop_a` into `o_resp` and go to RESP.
- **RESP.** `o_ack[grant]=1` for 1 cycle. Update `last_grant` to the grantee, then return to IDLE.
- **REJECT.** `o_resp` = "BadUser", right-aligned and zero-padded to O_A_NUM_BITS. `o_ack[grant]=1` for 1 cycle. Update `last_grant`, then return to IDLE. The shop is never strobed on a rejected request.
- **Output persistence.**
  - `o_shop_u` and `o_shop_a` hold their last values between transactions.
  - `o_resp` holds until the next RESP or REJECT.
  - `o_grant_id` holds until the next grant.
- **Requester rules.**
  - A requester holds `i_req` and its data until its ack.
  - Data is sampled only at grant, so changes after grant are ignored.
  - Dropping `i_req` after grant does not abort the transaction; the ack still pulses.
  - If `i_req` is still high in the cycle after the ack, that is a new request, arbitrated behind the other pending requesters.
- **Fairness.** With all NUM_REQ requesting continuously, grants rotate 0,1,...,NUM_REQ-1,0 and so on; no requester waits more than NUM_REQ-1 transactions.
- **Simultaneous events.** A request arriving during a transaction waits for IDLE.
- **Reset.** On reset, asserted mid-transaction or not:
  - FSM goes to IDLE and `last_grant` = NUM_REQ-1, so requester 0 has first priority.
  - All outputs are 0, including `o_shop_rdy`, `o_ack`, `o_resp`, `o_grant_id` and `o_busy`.
  - Any in-flight transaction is discarded with no ack.

## Timing
- Let cycle 0 be the IDLE cycle in which `i_req` is sampled high.
- Cycle 1 is SETUP: shop u/a valid, `o_busy=1`.
- Cycle 2 is STROBE: `o_shop_rdy=1`.
- Cycles 3 to 2+RESP_WAIT are WAIT.
- Cycle 3+RESP_WAIT is RESP: `o_ack` and `o_resp` valid.
- Accepted-transaction latency is 3+RESP_WAIT cycles from request to ack; with the default RESP_WAIT=2 that is 5 cycles.
- Rejected transactions ack in cycle 2 (REJECT state).
- The back-to-back issue interval is 4+RESP_WAIT cycles, including the IDLE grant cycle.
- `o_shop_rdy` is never high in two consecutive cycles.
- `o_ack` has at most one bit set at any time.

## Test plan
- **Reset:** hold `i_reset_n=0` for 2 cycles with `i_req=4'b1111` → all outputs 0; after release the first grant is requester 0.
- **Single accepted request:** requester 2 sends u=4, "Login"; shop model returns "OK" after 2 cycles.
  - `o_shop_rdy` high only in cycle 2, with `o_shop_u=4` and `o_shop_a="Login"`.
  - `o_ack=4'b0100` and `o_resp="OK"` in cycle 5.
- **Round-robin:** all four requesters hold requests → ack order 0,1,2,3,0; consecutive acks 6 cycles apart.
- **Reject:** requester 1 sends u=7, "Buy" → `o_ack=4'b0010` in cycle 2, `o_resp="BadUser"`, `o_shop_rdy` never asserted.
- **Request dropped after grant:** requester 3 drops `i_req` in cycle 1 → the ack still pulses in cycle 5 and no re-grant follows.
- **Reset mid-WAIT:** assert reset in cycle 3 → no ack, `o_shop_rdy` stays 0, and the next grant goes to the lowest pending index.
